// File: rtl/dice_pkg.sv
// Shared constants and types for the dice roller display path.
package dice_pkg;

  // Digit codes: 0-9 are BCD, 10-14 show a dash, 15 is dark.
  localparam logic [3:0] DIGIT_BLANK    = 4'd15;
  localparam logic [3:0] DIGIT_DASH_MIN = 4'd10;

  // Active-high segment patterns, bit0=a .. bit6=g, bit7=dp.
  localparam logic [7:0] SEG_0    = 8'h3F;
  localparam logic [7:0] SEG_1    = 8'h06;
  localparam logic [7:0] SEG_2    = 8'h5B;
  localparam logic [7:0] SEG_3    = 8'h4F;
  localparam logic [7:0] SEG_4    = 8'h66;
  localparam logic [7:0] SEG_5    = 8'h6D;
  localparam logic [7:0] SEG_6    = 8'h7D;
  localparam logic [7:0] SEG_7    = 8'h07;
  localparam logic [7:0] SEG_8    = 8'h7F;
  localparam logic [7:0] SEG_9    = 8'h6F;
  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_OFF  = 8'h00;

  typedef enum logic [1:0] {
    StDeadOnes,
    StShowOnes,
    StDeadTens,
    StShowTens
  } mux_state_t;

endpackage

// File: rtl/sevenseg_decode.sv
// Combinational digit-code to active-high segment pattern decode.
module sevenseg_decode
  import dice_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  // Map each code to its pattern; codes 10-14 fall through to a dash.
  always_comb begin
    seg = SEG_OFF;
    case (digit)
      4'd0:        seg = SEG_0;
      4'd1:        seg = SEG_1;
      4'd2:        seg = SEG_2;
      4'd3:        seg = SEG_3;
      4'd4:        seg = SEG_4;
      4'd5:        seg = SEG_5;
      4'd6:        seg = SEG_6;
      4'd7:        seg = SEG_7;
      4'd8:        seg = SEG_8;
      4'd9:        seg = SEG_9;
      DIGIT_BLANK: seg = SEG_OFF;
      default:     seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/sevenseg_mux_driver.sv
// Two-digit multiplexed seven-segment driver with dead-time and selectable polarity.
module sevenseg_mux_driver
  import dice_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = 1000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] digit1,
  input  logic [3:0] digit10,
  input  logic       blank_lz,
  input  logic       seg_active_high,
  input  logic       com_active_high,
  output logic [7:0] seg_out,
  output logic [1:0] com_out,
  output logic [1:0] com_oe
);

  localparam int unsigned MaxCyc = (SHOW_CYCLES > DEAD_CYCLES) ? SHOW_CYCLES : DEAD_CYCLES;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] DeadLast = CntW'(DEAD_CYCLES - 1);
  localparam logic [CntW-1:0] ShowLast = CntW'(SHOW_CYCLES - 1);

  mux_state_t      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      raw_seg_q, raw_seg_d;
  logic [1:0]      raw_com_q, raw_com_d;
  logic            com_oe_q;

  logic [3:0] tens_eff;
  logic [3:0] sel_digit;
  logic [7:0] dec_seg;
  logic [1:0] show_com;

  // Pick the digit about to be latched and the common it will drive.
  always_comb begin
    tens_eff  = (blank_lz && (digit10 == 4'd0)) ? DIGIT_BLANK : digit10;
    sel_digit = (state_q == StDeadTens) ? tens_eff : digit1;
    show_com  = 2'b00;
    if (sel_digit != DIGIT_BLANK) begin
      show_com = (state_q == StDeadTens) ? 2'b10 : 2'b01;
    end
  end

  sevenseg_decode u_decode (
    .digit (sel_digit),
    .seg   (dec_seg)
  );

  // Next-state: every transition passes through raw outputs of zero, so the
  // two commons can never overlap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    raw_seg_d = raw_seg_q;
    raw_com_d = raw_com_q;
    if (!ena) begin
      state_d   = StDeadOnes;
      cnt_d     = '0;
      raw_seg_d = SEG_OFF;
      raw_com_d = 2'b00;
    end else begin
      unique case (state_q)
        StDeadOnes, StDeadTens: begin
          raw_seg_d = SEG_OFF;
          raw_com_d = 2'b00;
          if (cnt_q == DeadLast) begin
            // Latch point: the raw registers hold the decoded digit for the
            // whole SHOW phase, so later input changes are ignored.
            state_d   = (state_q == StDeadOnes) ? StShowOnes : StShowTens;
            cnt_d     = '0;
            raw_seg_d = dec_seg;
            raw_com_d = show_com;
          end
        end
        StShowOnes, StShowTens: begin
          if (cnt_q == ShowLast) begin
            state_d   = (state_q == StShowOnes) ? StDeadTens : StDeadOnes;
            cnt_d     = '0;
            raw_seg_d = SEG_OFF;
            raw_com_d = 2'b00;
          end
        end
        default: begin
          state_d   = StDeadOnes;
          cnt_d     = '0;
          raw_seg_d = SEG_OFF;
          raw_com_d = 2'b00;
        end
      endcase
    end
  end

  // State, counter and raw output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StDeadOnes;
      cnt_q     <= '0;
      raw_seg_q <= SEG_OFF;
      raw_com_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      raw_seg_q <= raw_seg_d;
      raw_com_q <= raw_com_d;
    end
  end

  // Common output enables turn on at the first edge after reset and stay on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      com_oe_q <= 1'b0;
    end else begin
      com_oe_q <= 1'b1;
    end
  end

  // Polarity mapping is combinational so a change applies in the same cycle.
  always_comb begin
    seg_out = seg_active_high ? raw_seg_q : ~raw_seg_q;
    com_out = com_active_high ? raw_com_q : ~raw_com_q;
    com_oe  = {2{com_oe_q}};
  end

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Directed and randomized checks for the multiplexed seven-segment driver.
module tb_sevenseg_mux_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [3:0] digit1;
  logic [3:0] digit10;
  logic       blank_lz;
  logic       seg_active_high;
  logic       com_active_high;
  logic [7:0] seg_out;
  logic [1:0] com_out;
  logic [1:0] com_oe;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_seg;
  logic [1:0] exp_com;
  logic [3:0] eff;

  sevenseg_mux_driver #(
    .SHOW_CYCLES (8),
    .DEAD_CYCLES (2)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ena             (ena),
    .digit1          (digit1),
    .digit10         (digit10),
    .blank_lz        (blank_lz),
    .seg_active_high (seg_active_high),
    .com_active_high (com_active_high),
    .seg_out         (seg_out),
    .com_out         (com_out),
    .com_oe          (com_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seg_tab(input logic [3:0] d);
    case (d)
      4'd0:  return 8'h3F;
      4'd1:  return 8'h06;
      4'd2:  return 8'h5B;
      4'd3:  return 8'h4F;
      4'd4:  return 8'h66;
      4'd5:  return 8'h6D;
      4'd6:  return 8'h7D;
      4'd7:  return 8'h07;
      4'd8:  return 8'h7F;
      4'd9:  return 8'h6F;
      4'd15: return 8'h00;
      default: return 8'h40;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Advance n clocks, checking segments and commons after each edge.
  task automatic run_phase(input string tag, input int n, input logic [7:0] seg,
                           input logic [1:0] com);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_seg"}, seg_out, seg);
      check({tag, "_com"}, {6'b0, com_out}, {6'b0, com});
    end
  endtask

  // One randomized cycle; kind 0=dead, 1=ones, 2=tens; first marks a latch edge.
  task automatic rand_cycle(input int kind, input bit first);
    digit1   = 4'($urandom_range(0, 15));
    digit10  = 4'($urandom_range(0, 15));
    blank_lz = 1'($urandom_range(0, 1));
    if (first && kind == 1) begin
      exp_seg = seg_tab(digit1);
      exp_com = (digit1 == 4'd15) ? 2'b00 : 2'b01;
    end else if (first && kind == 2) begin
      eff     = (blank_lz && digit10 == 4'd0) ? 4'd15 : digit10;
      exp_seg = seg_tab(eff);
      exp_com = (eff == 4'd15) ? 2'b00 : 2'b10;
    end else if (kind == 0) begin
      exp_seg = 8'h00;
      exp_com = 2'b00;
    end
    @(posedge clk);
    @(negedge clk);
    check("rnd_seg", seg_out, exp_seg);
    check("rnd_com", {6'b0, com_out}, {6'b0, exp_com});
    check("rnd_com_excl", {7'b0, &com_out}, 8'h00);
  endtask

  initial begin
    rst_n           = 1'b0;
    ena             = 1'b1;
    digit1          = 4'd4;
    digit10         = 4'd2;
    blank_lz        = 1'b0;
    seg_active_high = 1'b1;
    com_active_high = 1'b1;

    // Reset state, both polarities.
    #12;
    check("rst_seg", seg_out, 8'h00);
    check("rst_com", {6'b0, com_out}, 8'h00);
    check("rst_oe", {6'b0, com_oe}, 8'h00);
    seg_active_high = 1'b0;
    com_active_high = 1'b0;
    #1;
    check("rst_seg_inv", seg_out, 8'hFF);
    check("rst_com_inv", {6'b0, com_out}, 8'h03);
    seg_active_high = 1'b1;
    com_active_high = 1'b1;

    // Test 1: basic refresh, digits 4/2.
    @(negedge clk);
    rst_n = 1'b1;
    run_phase("t1_dead0", 1, 8'h00, 2'b00);
    check("t1_oe", {6'b0, com_oe}, 8'h03);
    run_phase("t1_ones", 8, 8'h66, 2'b01);
    run_phase("t1_dead", 2, 8'h00, 2'b00);
    run_phase("t1_tens", 8, 8'h5B, 2'b10);
    run_phase("t1_dead", 2, 8'h00, 2'b00);

    // Test 2: inverted polarities and a mid-phase segment polarity toggle.
    seg_active_high = 1'b0;
    com_active_high = 1'b0;
    #1;
    check("t2_dead_seg", seg_out, 8'hFF);
    check("t2_dead_com", {6'b0, com_out}, 8'h03);
    run_phase("t2_ones", 4, 8'h99, 2'b10);
    seg_active_high = 1'b1;
    #1;
    check("t2_toggle", seg_out, 8'h66);
    seg_active_high = 1'b0;
    run_phase("t2_ones", 4, 8'h99, 2'b10);
    run_phase("t2_dead", 2, 8'hFF, 2'b11);
    run_phase("t2_tens", 8, 8'hA4, 2'b01);
    run_phase("t2_dead", 2, 8'hFF, 2'b11);
    seg_active_high = 1'b1;
    com_active_high = 1'b1;

    // Test 3: leading-zero blanking.
    digit1   = 4'd7;
    digit10  = 4'd0;
    blank_lz = 1'b1;
    run_phase("t3_ones", 8, 8'h07, 2'b01);
    run_phase("t3_dead", 2, 8'h00, 2'b00);
    run_phase("t3_lz_tens", 8, 8'h00, 2'b00);
    run_phase("t3_dead", 2, 8'h00, 2'b00);
    blank_lz = 1'b0;
    run_phase("t3_ones", 8, 8'h07, 2'b01);
    run_phase("t3_dead", 2, 8'h00, 2'b00);
    run_phase("t3_nolz_tens", 8, 8'h3F, 2'b10);
    run_phase("t3_dead", 2, 8'h00, 2'b00);
    digit1   = 4'd0;
    blank_lz = 1'b1;
    run_phase("t3_zero_ones", 8, 8'h3F, 2'b01);
    run_phase("t3_dead", 2, 8'h00, 2'b00);
    run_phase("t3_zero_tens", 8, 8'h00, 2'b00);
    run_phase("t3_dead", 2, 8'h00, 2'b00);
    blank_lz = 1'b0;

    // Test 4: blank and dash codes, mid-SHOW input change ignored.
    digit1  = 4'd15;
    digit10 = 4'd12;
    run_phase("t4_blank_ones", 8, 8'h00, 2'b00);
    run_phase("t4_dead", 2, 8'h00, 2'b00);
    run_phase("t4_dash_tens", 8, 8'h40, 2'b10);
    run_phase("t4_dead", 2, 8'h00, 2'b00);
    digit1 = 4'd3;
    run_phase("t4_ones3", 3, 8'h4F, 2'b01);
    digit1 = 4'd8;
    run_phase("t4_ones3_hold", 5, 8'h4F, 2'b01);
    run_phase("t4_dead", 2, 8'h00, 2'b00);
    run_phase("t4_tens", 8, 8'h40, 2'b10);
    run_phase("t4_dead", 2, 8'h00, 2'b00);
    run_phase("t4_ones8", 8, 8'h7F, 2'b01);
    run_phase("t4_dead", 2, 8'h00, 2'b00);

    // Test 5: enable drop mid-SHOW_TENS, resume, then async reset.
    run_phase("t5_tens", 3, 8'h40, 2'b10);
    ena = 1'b0;
    run_phase("t5_ena_off", 4, 8'h00, 2'b00);
    check("t5_oe_ena", {6'b0, com_oe}, 8'h03);
    ena = 1'b1;
    run_phase("t5_resume_dead", 1, 8'h00, 2'b00);
    run_phase("t5_resume_ones", 4, 8'h7F, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_seg", seg_out, 8'h00);
    check("t5_rst_com", {6'b0, com_out}, 8'h00);
    check("t5_rst_oe", {6'b0, com_oe}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_phase("t6_dead0", 1, 8'h00, 2'b00);

    // Test 6: random digits over many refresh periods.
    exp_seg = 8'h00;
    exp_com = 2'b00;
    eff     = 4'd0;
    for (int p = 0; p < 1000; p++) begin
      for (int k = 0; k < 8; k++) rand_cycle(1, k == 0);
      for (int k = 0; k < 2; k++) rand_cycle(0, 1'b0);
      for (int k = 0; k < 8; k++) rand_cycle(2, k == 0);
      for (int k = 0; k < 2; k++) rand_cycle(0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
